// File: rtl/stopwatch_datapath.sv
// rtl/stopwatch_datapath.sv - centisecond stopwatch: prescaler plus msec/sec/min/hour cascade
module stopwatch_datapath #(
    parameter int CLK_FREQ = 100_000_000,
    parameter int TICK_HZ  = 100
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_run_stop,
    input  logic       i_clear,
    output logic [6:0] o_msec,
    output logic [5:0] o_sec,
    output logic [5:0] o_min,
    output logic [4:0] o_hour,
    output logic       o_tick
);

    localparam int DIV   = CLK_FREQ / TICK_HZ;
    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [6:0]       msec_nxt;
    logic [5:0]       sec_nxt;
    logic [5:0]       min_nxt;
    logic [4:0]       hour_nxt;
    logic             tick_nxt;

    // Next-state: clear beats run beats hold; the whole carry chain resolves in one tick
    always_comb begin
        cnt_nxt  = r_cnt;
        msec_nxt = o_msec;
        sec_nxt  = o_sec;
        min_nxt  = o_min;
        hour_nxt = o_hour;
        tick_nxt = 1'b0;
        if (i_clear) begin
            cnt_nxt  = '0;
            msec_nxt = '0;
            sec_nxt  = '0;
            min_nxt  = '0;
            hour_nxt = '0;
        end else if (i_run_stop) begin
            if (r_cnt == CNT_LAST) begin
                cnt_nxt  = '0;
                tick_nxt = 1'b1;
                if (o_msec == 7'd99) begin
                    msec_nxt = '0;
                    if (o_sec == 6'd59) begin
                        sec_nxt = '0;
                        if (o_min == 6'd59) begin
                            min_nxt  = '0;
                            hour_nxt = (o_hour == 5'd23) ? 5'd0 : o_hour + 5'd1;
                        end else begin
                            min_nxt = o_min + 6'd1;
                        end
                    end else begin
                        sec_nxt = o_sec + 6'd1;
                    end
                end else begin
                    msec_nxt = o_msec + 7'd1;
                end
            end else begin
                cnt_nxt = r_cnt + 1'b1;
            end
        end
    end

    // State registers; every output comes straight from a flop
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt  <= '0;
            o_msec <= '0;
            o_sec  <= '0;
            o_min  <= '0;
            o_hour <= '0;
            o_tick <= 1'b0;
        end else begin
            r_cnt  <= cnt_nxt;
            o_msec <= msec_nxt;
            o_sec  <= sec_nxt;
            o_min  <= min_nxt;
            o_hour <= hour_nxt;
            o_tick <= tick_nxt;
        end
    end

endmodule

// File: tb/tb_stopwatch_datapath.sv
// tb/tb_stopwatch_datapath.sv - directed self-checking bench for stopwatch_datapath (DIV=10)
module tb_stopwatch_datapath;

    logic       clk;
    logic       reset;
    logic       i_run_stop;
    logic       i_clear;
    logic [6:0] o_msec;
    logic [5:0] o_sec;
    logic [5:0] o_min;
    logic [4:0] o_hour;
    logic       o_tick;

    int checks;
    int failures;

    stopwatch_datapath #(
        .CLK_FREQ(1000),
        .TICK_HZ (100)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .i_run_stop(i_run_stop),
        .i_clear   (i_clear),
        .o_msec    (o_msec),
        .o_sec     (o_sec),
        .o_min     (o_min),
        .o_hour    (o_hour),
        .o_tick    (o_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_time(input string tag, input int h, input int m, input int s, input int cs);
        check({tag, ".hour"}, 32'(o_hour), 32'(h));
        check({tag, ".min"},  32'(o_min),  32'(m));
        check({tag, ".sec"},  32'(o_sec),  32'(s));
        check({tag, ".msec"}, 32'(o_msec), 32'(cs));
    endtask

    initial begin
        checks     = 0;
        failures   = 0;
        reset      = 1'b1;
        i_run_stop = 1'b0;
        i_clear    = 1'b0;
        step(3);
        check_time("reset", 0, 0, 0, 0);
        check("reset.tick", 32'(o_tick), 32'd0);

        // first ticks from a fresh reset: edges 10 and 20
        reset      = 1'b0;
        i_run_stop = 1'b1;
        step(9);
        check("edge9.msec", 32'(o_msec), 32'd0);
        check("edge9.tick", 32'(o_tick), 32'd0);
        step(1);
        check("edge10.msec", 32'(o_msec), 32'd1);
        check("edge10.tick", 32'(o_tick), 32'd1);
        step(1);
        check("edge11.tick", 32'(o_tick), 32'd0);
        step(9);
        check("edge20.msec", 32'(o_msec), 32'd2);
        check("edge20.tick", 32'(o_tick), 32'd1);
        step(1);
        check("edge21.tick", 32'(o_tick), 32'd0);

        // run 25, stop 50, run 5: partial count survives the pause
        i_clear = 1'b1;
        step(1);
        i_clear = 1'b0;
        step(25);
        check("run25.msec", 32'(o_msec), 32'd2);
        i_run_stop = 1'b0;
        step(50);
        check("stop50.msec", 32'(o_msec), 32'd2);
        check("stop50.tick", 32'(o_tick), 32'd0);
        i_run_stop = 1'b1;
        step(4);
        check("resume4.msec", 32'(o_msec), 32'd2);
        step(1);
        check("resume5.msec", 32'(o_msec), 32'd3);
        check("resume5.tick", 32'(o_tick), 32'd1);

        // async reset at 00:00:00.07 with prescaler at 6
        i_clear = 1'b1;
        step(1);
        i_clear = 1'b0;
        step(76);
        check("pre_rst.msec", 32'(o_msec), 32'd7);
        #3 reset = 1'b1;
        #1;
        check("async_rst.msec", 32'(o_msec), 32'd0);
        #2 reset = 1'b0;
        step(9);
        check("post_rst9.msec", 32'(o_msec), 32'd0);
        step(1);
        check("post_rst10.msec", 32'(o_msec), 32'd1);
        check("post_rst10.tick", 32'(o_tick), 32'd1);

        // run through the msec->sec->min cascade
        i_clear = 1'b1;
        step(1);
        i_clear = 1'b0;
        step(1000);
        check_time("t1s", 0, 0, 1, 0);
        step(58990);
        check_time("t59_99", 0, 0, 59, 99);
        step(10);
        check_time("t1m", 0, 1, 0, 0);
        check("t1m.tick", 32'(o_tick), 32'd1);
        step(2340);
        check_time("t1m2s34", 0, 1, 2, 34);

        // clear together with run wins and holds everything at zero
        i_clear = 1'b1;
        step(1);
        check_time("clr1", 0, 0, 0, 0);
        check("clr1.tick", 32'(o_tick), 32'd0);
        step(25);
        check_time("clr26", 0, 0, 0, 0);

        // preload 23:59:59.99 while stopped, then one tick rolls everything over
        i_clear    = 1'b0;
        i_run_stop = 1'b0;
        force dut.o_hour = 5'd23;
        force dut.o_min  = 6'd59;
        force dut.o_sec  = 6'd59;
        force dut.o_msec = 7'd99;
        step(1);
        release dut.o_hour;
        release dut.o_min;
        release dut.o_sec;
        release dut.o_msec;
        step(1);
        check_time("preload", 23, 59, 59, 99);
        i_run_stop = 1'b1;
        step(9);
        check_time("roll9", 23, 59, 59, 99);
        step(1);
        check_time("roll", 0, 0, 0, 0);
        check("roll.tick", 32'(o_tick), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
